// File: rtl/bp_fe_ras_ctrl.sv
// RAS control: decodes JAL/JALR call/return hints, drives RAS push/pop and a registered return prediction.
// Optional BP_FE_RAS_CTRL_STATS_EN adds saturating push/pop/miss counters.
module bp_fe_ras_ctrl #(
  parameter int eaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     instr_v_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [eaddr_width_p-1:0] pc_i,
  input  logic                     flush_i,
  output logic                     ras_push_o,
  output logic                     ras_pop_o,
  output logic [63:0]              ras_data_o,
  input  logic [63:0]              ras_data_i,
  input  logic                     ras_v_i,
  output logic                     pred_v_o,
  output logic [eaddr_width_p-1:0] pred_target_o,
  output logic [1:0]               pred_kind_o
`ifdef BP_FE_RAS_CTRL_STATS_EN
  ,
  output logic [31:0]              stat_call_o,
  output logic [31:0]              stat_ret_o,
  output logic [31:0]              stat_ret_miss_o
`endif
);

  typedef enum logic {IDLE, SWAP} state_e;
  typedef enum logic [1:0] {K_NONE = 2'b00, K_CALL = 2'b01, K_RET = 2'b10, K_CORO = 2'b11} kind_e;

  state_e                   state_reg, state_next;
  logic [eaddr_width_p-1:0] swap_data_reg;
  logic [eaddr_width_p-1:0] pc_plus4;
  logic                     accept;
  logic                     latch_en;
  kind_e                    cls;

  logic [6:0] opcode;
  logic [4:0] rd, rs1;
  logic [2:0] funct3;
  logic       is_jal, is_jalr, link_rd, link_rs1;

  assign opcode   = instr_i[6:0];
  assign rd       = instr_i[11:7];
  assign funct3   = instr_i[14:12];
  assign rs1      = instr_i[19:15];
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

  // Wraps modulo 2^eaddr_width_p; carry out is intentionally discarded.
  assign pc_plus4 = pc_i + eaddr_width_p'(4);

  logic unused_bits;
  assign unused_bits = ^{instr_i[31:20], ras_data_i[63:eaddr_width_p]};

  always_comb begin
    cls = K_NONE;
    if (is_jal) begin
      if (link_rd) cls = K_CALL;
    end else if (is_jalr) begin
      if (link_rd && !link_rs1)                   cls = K_CALL;
      else if (!link_rd && link_rs1)              cls = K_RET;
      else if (link_rd && link_rs1 && rd == rs1)  cls = K_CALL;
      else if (link_rd && link_rs1)               cls = K_CORO;
    end
  end

  always_comb begin
    state_next    = state_reg;
    instr_ready_o = 1'b0;
    ras_push_o    = 1'b0;
    ras_pop_o     = 1'b0;
    ras_data_o    = {{(64-eaddr_width_p){1'b0}}, pc_plus4};
    accept        = 1'b0;
    latch_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready_o = 1'b1;
        // Strobes are also held off while reset is asserted.
        accept = instr_v_i && !flush_i && reset_n_i;
        if (accept) begin
          case (cls)
            K_CALL: ras_push_o = 1'b1;
            K_RET:  ras_pop_o  = 1'b1;
            K_CORO: begin
              ras_pop_o  = 1'b1;
              latch_en   = 1'b1;
              state_next = SWAP;
            end
            default: ;
          endcase
        end
      end
      SWAP: begin
        ras_push_o = !flush_i;
        ras_data_o = {{(64-eaddr_width_p){1'b0}}, swap_data_reg};
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      swap_data_reg <= '0;
      pred_v_o      <= 1'b0;
      pred_target_o <= '0;
      pred_kind_o   <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (latch_en) swap_data_reg <= pc_plus4;
      pred_v_o    <= 1'b0;
      pred_kind_o <= 2'b00;
      if (accept) begin
        pred_kind_o <= cls;
        if (cls == K_RET || cls == K_CORO) begin
          pred_v_o      <= ras_v_i;
          pred_target_o <= ras_data_i[eaddr_width_p-1:0];
        end
      end
    end
  end

`ifdef BP_FE_RAS_CTRL_STATS_EN
  logic [31:0] stat_call_reg, stat_ret_reg, stat_miss_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_call_reg <= '0;
      stat_ret_reg  <= '0;
      stat_miss_reg <= '0;
    end else begin
      if (ras_push_o && stat_call_reg != 32'hFFFF_FFFF) stat_call_reg <= stat_call_reg + 32'd1;
      if (ras_pop_o && stat_ret_reg != 32'hFFFF_FFFF)   stat_ret_reg  <= stat_ret_reg + 32'd1;
      if (ras_pop_o && !ras_v_i && stat_miss_reg != 32'hFFFF_FFFF)
        stat_miss_reg <= stat_miss_reg + 32'd1;
    end
  end

  assign stat_call_o     = stat_call_reg;
  assign stat_ret_o      = stat_ret_reg;
  assign stat_ret_miss_o = stat_miss_reg;
`endif

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Bench for bp_fe_ras_ctrl: directed scenarios then random traffic against a transaction-level
// model with a queue-based RAS.
module tb_bp_fe_ras_ctrl;
  localparam int E = 39;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          instr_v_i;
  logic          instr_ready_o;
  logic [31:0]   instr_i;
  logic [E-1:0]  pc_i;
  logic          flush_i;
  logic          ras_push_o, ras_pop_o;
  logic [63:0]   ras_data_o, ras_data_i;
  logic          ras_v_i;
  logic          pred_v_o;
  logic [E-1:0]  pred_target_o;
  logic [1:0]    pred_kind_o;
`ifdef BP_FE_RAS_CTRL_STATS_EN
  logic [31:0]   stat_call_o, stat_ret_o, stat_ret_miss_o;
`endif

  bp_fe_ras_ctrl #(.eaddr_width_p(E)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .instr_v_i(instr_v_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .ras_push_o(ras_push_o), .ras_pop_o(ras_pop_o),
    .ras_data_o(ras_data_o), .ras_data_i(ras_data_i), .ras_v_i(ras_v_i), .pred_v_o(pred_v_o),
    .pred_target_o(pred_target_o), .pred_kind_o(pred_kind_o)
`ifdef BP_FE_RAS_CTRL_STATS_EN
    , .stat_call_o(stat_call_o), .stat_ret_o(stat_ret_o), .stat_ret_miss_o(stat_ret_miss_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [63:0] stack[$];
  bit          swap_pending;
  logic [E-1:0] swap_data;
  bit          exp_pv;
  logic [E-1:0] exp_pt;
  logic [1:0]  exp_pk;
  int          cnt_push, cnt_pop, cnt_miss;

  // 0 none, 1 call, 2 return, 3 coroutine
  function automatic logic [1:0] classify(input logic [31:0] ins);
    logic [4:0] rd, rs1;
    bit lrd, lrs;
    rd  = ins[11:7];
    rs1 = ins[19:15];
    lrd = (rd == 1) || (rd == 5);
    lrs = (rs1 == 1) || (rs1 == 5);
    if (ins[6:0] == 7'h6F) return lrd ? 2'd1 : 2'd0;
    if (ins[6:0] != 7'h67 || ins[14:12] != 3'd0) return 2'd0;
    if (lrd && lrs) return (rd == rs1) ? 2'd1 : 2'd3;
    if (lrd) return 2'd1;
    if (lrs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3, input logic [4:0] rs1);
    logic [11:0] imm;
    imm = 12'($urandom);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom % 4)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [E-1:0] pc, input logic fl);
    bit push_e, pop_e, rv;
    logic [63:0] data_e, rd_top;
    logic [1:0] k;
    instr_v_i = v; instr_i = ins; pc_i = pc; flush_i = fl;
    rv = (stack.size() > 0);
    rd_top = rv ? stack[$] : {$urandom, $urandom};
    ras_v_i = rv; ras_data_i = rd_top;
    k = classify(ins);
    push_e = 0; pop_e = 0; data_e = '0;
    #1;
    check("ready", instr_ready_o, !swap_pending);
    if (swap_pending) begin
      push_e = !fl;
      data_e = {25'd0, swap_data};
    end else if (v && !fl) begin
      push_e = (k == 2'd1);
      pop_e  = (k == 2'd2) || (k == 2'd3);
      data_e = {25'd0, E'(pc + 4)};
    end
    check("push", ras_push_o, push_e);
    check("pop", ras_pop_o, pop_e);
    if (push_e) check("push_data", ras_data_o, data_e);
    @(posedge clk_i);
    exp_pv = 0; exp_pk = 2'd0;
    if (swap_pending) begin
      swap_pending = 0;
    end else if (v && !fl) begin
      exp_pk = k;
      if (pop_e) begin
        exp_pv = rv;
        exp_pt = rd_top[E-1:0];
      end
      if (k == 2'd3) begin
        swap_pending = 1;
        swap_data = E'(pc + 4);
      end
    end
    if (pop_e) begin
      cnt_pop++;
      if (!rv) cnt_miss++;
      if (rv) void'(stack.pop_back());
    end
    if (push_e) begin
      cnt_push++;
      stack.push_back(data_e);
      if (stack.size() > 8) stack.delete(0);
    end
    #1;
    check("pred_v", pred_v_o, exp_pv);
    check("pred_kind", pred_kind_o, exp_pk);
    if (exp_pv) check("pred_target", pred_target_o, exp_pt);
`ifdef BP_FE_RAS_CTRL_STATS_EN
    check("stat_call", stat_call_o, cnt_push);
    check("stat_ret", stat_ret_o, cnt_pop);
    check("stat_miss", stat_ret_miss_o, cnt_miss);
`endif
    $display("cyc v=%0d ins=%08h pc=%010h fl=%0d push=%0d pop=%0d pv=%0d pk=%0d",
             v, ins, pc, fl, ras_push_o, ras_pop_o, pred_v_o, pred_kind_o);
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, instr_ready_o, 1'b1);
    check({tag, "_push"}, ras_push_o, 1'b0);
    check({tag, "_pop"}, ras_pop_o, 1'b0);
    check({tag, "_pred_v"}, pred_v_o, 1'b0);
    check({tag, "_kind"}, pred_kind_o, 2'd0);
    check({tag, "_target"}, pred_target_o, '0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [E-1:0] pc;
    reset_n_i = 0; instr_v_i = 0; instr_i = '0; pc_i = '0; flush_i = 0;
    ras_data_i = '0; ras_v_i = 0;
    swap_pending = 0; swap_data = '0; exp_pv = 0; exp_pt = '0; exp_pk = 0;
    cnt_push = 0; cnt_pop = 0; cnt_miss = 0;
    repeat (2) @(negedge clk_i);
    #1;
    check_reset_outputs("rst");
    reset_n_i = 1;
    @(negedge clk_i);

    // CALL then RETURN (stack supplies 0x80000004), then RETURN on empty RAS
    step(1, 32'h008000EF, 39'h80000000, 0);
    check("call_kind", pred_kind_o, 2'b01);
    step(1, 32'h00008067, 39'h80000100, 0);
    check("ret_target", pred_target_o, 39'h80000004);
    check("ret_pred_v", pred_v_o, 1'b1);
    step(1, 32'h00008067, 39'h80000200, 0);
    check("ret_empty_pv", pred_v_o, 1'b0);

    // Coroutine with PC wrap
    step(1, {12'h0, 5'd5, 3'd0, 5'd1, 7'h67}, 39'h7FFFFFFFFC, 0);
    step(0, 32'h0, 39'h0, 0);
    step(0, 32'h0, 39'h0, 0);

    // Flush in SWAP, then flush with a CALL present
    step(1, {12'h0, 5'd1, 3'd0, 5'd5, 7'h67}, 39'h1000, 0);
    step(0, 32'h0, 39'h0, 1);
    step(1, 32'h008000EF, 39'h2000, 1);

    // Reset mid-SWAP
    step(1, {12'h0, 5'd5, 3'd0, 5'd1, 7'h67}, 39'h3000, 0);
    instr_v_i = 1; instr_i = 32'h008000EF; flush_i = 0;
    reset_n_i = 0;
    #1;
    check_reset_outputs("midswap");
    swap_pending = 0; exp_pv = 0; exp_pk = 0; cnt_push = 0; cnt_pop = 0; cnt_miss = 0;
    @(negedge clk_i);
    reset_n_i = 1;
    step(0, 32'h0, 39'h0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 5)
        0: ins = mk(7'h6F, pick_reg(), 3'($urandom), pick_reg());
        1, 2: ins = mk(7'h67, pick_reg(), 3'd0, pick_reg());
        3: ins = mk(7'h67, pick_reg(), 3'($urandom_range(7, 1)), pick_reg());
        default: ins = $urandom;
      endcase
      pc = ($urandom % 8 == 0) ? E'(39'h7FFFFFFFFC) : E'({$urandom, $urandom});
      step(($urandom % 4) != 0, ins, pc, ($urandom % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
